// File: rtl/types_pkg.sv
// Shared type definitions for the per-channel acquisition datapath.
package types_pkg;

    typedef enum logic [2:0] {
        STATE_STOPPED   = 3'd0,
        STATE_INIT      = 3'd1,
        STATE_ARMED     = 3'd2,
        STATE_TRIGGERED = 3'd3,
        STATE_READOUT   = 3'd4
    } state_t;

endpackage

// File: rtl/ch_acq_ctrl.sv
// Per-channel acquisition sequencer: STOPPED -> INIT -> ARMED -> TRIGGERED -> READOUT.
// Define CH_AUTO_REARM_EN to re-enter INIT after each readout instead of stopping.
module ch_acq_ctrl
    import types_pkg::*;
#(
    parameter int unsigned DEPTH_W = 6
) (
    input  logic               FCLK,
    input  logic               RSTB,
    input  logic               INST_START,
    input  logic               INST_STOP,
    input  logic               TRIGGER,
    input  logic [7:0]         INIT_CYCLES,
    input  logic [7:0]         POST_TRIG,
    input  logic               READOUT_DONE,
    output state_t             current_state,
    output logic [DEPTH_W-1:0] WR_PTR,
    output logic [DEPTH_W-1:0] TRIG_ADDR,
    output logic [DEPTH_W-1:0] STOP_ADDR,
    output logic               DATA_VALID,
    output logic [15:0]        TRIG_COUNT
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TCNT_W = 16;
    localparam logic [TCNT_W-1:0] TCNT_MAX = '1;

    logic               trig_meta;
    logic               trig_sync;
    logic [CNT_W-1:0]   init_cnt_q;
    logic [CNT_W-1:0]   post_cnt_q;

    state_t             state_d;
    logic [CNT_W-1:0]   init_cnt_d;
    logic [CNT_W-1:0]   post_cnt_d;
    logic [DEPTH_W-1:0] wr_ptr_d;
    logic [DEPTH_W-1:0] trig_addr_d;
    logic [DEPTH_W-1:0] stop_addr_d;
    logic               data_valid_d;
    logic [TCNT_W-1:0]  trig_count_d;

    // State, counters, captured addresses and the trigger synchronizer
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            current_state <= STATE_STOPPED;
            trig_meta     <= 1'b0;
            trig_sync     <= 1'b0;
            init_cnt_q    <= '0;
            post_cnt_q    <= '0;
            WR_PTR        <= '0;
            TRIG_ADDR     <= '0;
            STOP_ADDR     <= '0;
            DATA_VALID    <= 1'b0;
            TRIG_COUNT    <= '0;
        end else begin
            current_state <= state_d;
            trig_meta     <= TRIGGER;
            trig_sync     <= trig_meta;
            init_cnt_q    <= init_cnt_d;
            post_cnt_q    <= post_cnt_d;
            WR_PTR        <= wr_ptr_d;
            TRIG_ADDR     <= trig_addr_d;
            STOP_ADDR     <= stop_addr_d;
            DATA_VALID    <= data_valid_d;
            TRIG_COUNT    <= trig_count_d;
        end
    end

    // Next-state and datapath updates; an abort freezes everything except the state
    always_comb begin
        state_d      = current_state;
        init_cnt_d   = init_cnt_q;
        post_cnt_d   = post_cnt_q;
        wr_ptr_d     = WR_PTR;
        trig_addr_d  = TRIG_ADDR;
        stop_addr_d  = STOP_ADDR;
        trig_count_d = TRIG_COUNT;

        if (INST_STOP) begin
            state_d = STATE_STOPPED;
        end else begin
            unique case (current_state)
                STATE_STOPPED: begin
                    if (INST_START) begin
                        state_d      = STATE_INIT;
                        init_cnt_d   = INIT_CYCLES;
                        wr_ptr_d     = '0;
                        trig_count_d = '0;
                    end
                end
                STATE_INIT: begin
                    if (init_cnt_q == '0) begin
                        state_d = STATE_ARMED;
                    end else begin
                        init_cnt_d = init_cnt_q - CNT_W'(1);
                    end
                end
                STATE_ARMED: begin
                    wr_ptr_d = WR_PTR + DEPTH_W'(1);
                    if (trig_sync) begin
                        state_d     = STATE_TRIGGERED;
                        trig_addr_d = WR_PTR;
                        post_cnt_d  = POST_TRIG;
                        if (TRIG_COUNT != TCNT_MAX) begin
                            trig_count_d = TRIG_COUNT + TCNT_W'(1);
                        end
                    end
                end
                STATE_TRIGGERED: begin
                    // Pointer stops advancing on the edge that enters READOUT
                    if (post_cnt_q == '0) begin
                        state_d     = STATE_READOUT;
                        stop_addr_d = WR_PTR;
                    end else begin
                        post_cnt_d = post_cnt_q - CNT_W'(1);
                        wr_ptr_d   = WR_PTR + DEPTH_W'(1);
                    end
                end
                STATE_READOUT: begin
                    if (READOUT_DONE) begin
`ifdef CH_AUTO_REARM_EN
                        state_d    = STATE_INIT;
                        init_cnt_d = INIT_CYCLES;
                        wr_ptr_d   = '0;
`else
                        state_d    = STATE_STOPPED;
`endif
                    end
                end
                default: begin
                    state_d = STATE_STOPPED;
                end
            endcase
        end

        data_valid_d = (state_d == STATE_READOUT);
    end

endmodule

// File: tb/tb_ch_acq_ctrl.sv
// Scoreboard bench for ch_acq_ctrl: stimulus queues expected state-change events,
// a negedge monitor pops and checks them on every state change or probe strobe.
module tb_ch_acq_ctrl;
    import types_pkg::*;

    localparam int unsigned DEPTH_W = 6;
    localparam int DC = -1;

    logic               FCLK = 1'b0;
    logic               RSTB;
    logic               INST_START;
    logic               INST_STOP;
    logic               TRIGGER;
    logic [7:0]         INIT_CYCLES;
    logic [7:0]         POST_TRIG;
    logic               READOUT_DONE;
    state_t             current_state;
    logic [DEPTH_W-1:0] WR_PTR;
    logic [DEPTH_W-1:0] TRIG_ADDR;
    logic [DEPTH_W-1:0] STOP_ADDR;
    logic               DATA_VALID;
    logic [15:0]        TRIG_COUNT;

    typedef struct {
        int st;
        int ptr;
        int ta;
        int sa;
        int dv;
        int cnt;
        int dwell;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic  probe_req = 1'b0;

    ch_acq_ctrl #(.DEPTH_W(DEPTH_W)) dut (
        .FCLK         (FCLK),
        .RSTB         (RSTB),
        .INST_START   (INST_START),
        .INST_STOP    (INST_STOP),
        .TRIGGER      (TRIGGER),
        .INIT_CYCLES  (INIT_CYCLES),
        .POST_TRIG    (POST_TRIG),
        .READOUT_DONE (READOUT_DONE),
        .current_state(current_state),
        .WR_PTR       (WR_PTR),
        .TRIG_ADDR    (TRIG_ADDR),
        .STOP_ADDR    (STOP_ADDR),
        .DATA_VALID   (DATA_VALID),
        .TRIG_COUNT   (TRIG_COUNT)
    );

    always #5 FCLK = ~FCLK;

    task automatic tick(input int n);
        repeat (n) @(posedge FCLK);
        #1;
    endtask

    task automatic push(input string tag, input int st, input int ptr, input int ta,
                        input int sa, input int dv, input int cnt, input int dwell);
        exp_t e;
        e.st = st; e.ptr = ptr; e.ta = ta; e.sa = sa;
        e.dv = dv; e.cnt = cnt; e.dwell = dwell;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic chk(input string tag, input string fld, input int got, input int req);
        if (req >= 0) begin
            n_chk++;
            if (got != req) begin
                n_fail++;
                $display("FAIL %s.%s: got %0d, required %0d", tag, fld, got, req);
            end
        end
    endtask

    task automatic probe();
        probe_req = 1'b1;
        tick(1);
        probe_req = 1'b0;
    endtask

    // Monitor: dwell = cycles spent in the state that just ended
    state_t mon_prev;
    bit     mon_first = 1'b1;
    int     mon_dwell = 0;
    exp_t   mon_e;
    string  mon_tag;

    initial begin : monitor
        mon_prev = STATE_STOPPED;
        forever begin
            @(negedge FCLK);
            mon_dwell++;
            if (mon_first || current_state != mon_prev || probe_req) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: got state %0d ptr %0d, required no event",
                             int'(current_state), int'(WR_PTR));
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_tag = tag_q.pop_front();
                    chk(mon_tag, "state", int'(current_state), mon_e.st);
                    chk(mon_tag, "wr_ptr", int'(WR_PTR), mon_e.ptr);
                    chk(mon_tag, "trig_addr", int'(TRIG_ADDR), mon_e.ta);
                    chk(mon_tag, "stop_addr", int'(STOP_ADDR), mon_e.sa);
                    chk(mon_tag, "data_valid", int'(DATA_VALID), mon_e.dv);
                    chk(mon_tag, "trig_count", int'(TRIG_COUNT), mon_e.cnt);
                    chk(mon_tag, "dwell", mon_dwell, mon_e.dwell);
                end
                if (mon_first || current_state != mon_prev) mon_dwell = 0;
                mon_prev  = current_state;
                mon_first = 1'b0;
            end
        end
    end

    // One full acquisition with hand-computed trigger/stop addresses
    task automatic acq(input string tag, input int init_c, input int post, input int arm_wait,
                       input int done_wait, input int e_ta, input int e_sa);
        push({tag, "_init"}, STATE_INIT, 0, DC, DC, 0, 0, DC);
        push({tag, "_armed"}, STATE_ARMED, 0, DC, DC, 0, 0, init_c + 1);
        push({tag, "_trig"}, STATE_TRIGGERED, (e_ta + 1) % 64, e_ta, DC, 0, 1, arm_wait + 3);
        push({tag, "_readout"}, STATE_READOUT, e_sa, e_ta, e_sa, 1, 1, post + 1);
        push({tag, "_stopped"}, STATE_STOPPED, e_sa, e_ta, e_sa, 0, 1, done_wait);
        INIT_CYCLES = 8'(init_c);
        POST_TRIG   = 8'(post);
        INST_START  = 1'b1;
        tick(1);
        INST_START  = 1'b0;
        INIT_CYCLES = 8'd200;
        tick(1 + init_c + arm_wait);
        TRIGGER = 1'b1;
        tick(3);
        TRIGGER   = 1'b0;
        POST_TRIG = 8'd200;
        tick(post + 1);
        tick(done_wait - 1);
        READOUT_DONE = 1'b1;
        tick(1);
        READOUT_DONE = 1'b0;
        tick(2);
    endtask

    initial begin : stimulus
        RSTB = 1'b0; INST_START = 1'b0; INST_STOP = 1'b0; TRIGGER = 1'b0;
        INIT_CYCLES = 8'd0; POST_TRIG = 8'd0; READOUT_DONE = 1'b0;
        push("reset", STATE_STOPPED, 0, 0, 0, 0, 0, DC);
        tick(2);
        RSTB = 1'b1;
        tick(2);

        acq("basic", 3, 5, 10, 3, 12, 18);
        acq("wrap", 2, 20, 48, 3, 50, 7);
        acq("bound", 0, 0, 4, 3, 6, 7);

        // Abort in ARMED, then STOP held together with START and TRIGGER
        push("abort_init", STATE_INIT, 0, DC, DC, 0, 0, DC);
        push("abort_armed", STATE_ARMED, 0, DC, DC, 0, 0, 2);
        push("abort_stopped", STATE_STOPPED, 3, 6, 7, 0, 0, 4);
        push("collide_probe", STATE_STOPPED, 3, 6, 7, 0, 0, DC);
        INIT_CYCLES = 8'd1;
        INST_START  = 1'b1;
        tick(1);
        INST_START  = 1'b0;
        tick(5);
        INST_STOP = 1'b1;
        tick(1);
        INST_START = 1'b1;
        TRIGGER    = 1'b1;
        tick(3);
        probe();
        INST_STOP = 1'b0; INST_START = 1'b0; TRIGGER = 1'b0;
        tick(3);

        // Reset while TRIGGERED with TRIGGER held high
        push("rst_init", STATE_INIT, 0, DC, DC, 0, 0, DC);
        push("rst_armed", STATE_ARMED, 0, DC, DC, 0, 0, 1);
        push("rst_trig", STATE_TRIGGERED, 2, 1, DC, 0, 1, 2);
        push("rst_stopped", STATE_STOPPED, 0, 0, 0, 0, 0, DC);
        push("rst_hold_probe", STATE_STOPPED, 0, 0, 0, 0, 0, DC);
        INIT_CYCLES = 8'd0;
        POST_TRIG   = 8'd30;
        INST_START  = 1'b1;
        tick(1);
        INST_START = 1'b0;
        TRIGGER    = 1'b1;
        tick(6);
        RSTB = 1'b0;
        tick(2);
        RSTB = 1'b1;
        tick(10);
        probe();
        TRIGGER = 1'b0;
        tick(4);

        // Three triggers with READOUT_DONE after each
        INIT_CYCLES = 8'd1;
        POST_TRIG   = 8'd2;
`ifdef CH_AUTO_REARM_EN
        for (int i = 0; i < 3; i++) begin
            push("rearm_init", STATE_INIT, 0, DC, DC, 0, i, (i == 0) ? DC : 2);
            push("rearm_armed", STATE_ARMED, 0, DC, DC, 0, i, 2);
            push("rearm_trig", STATE_TRIGGERED, 3, 2, DC, 0, i + 1, 3);
            push("rearm_readout", STATE_READOUT, 5, 2, 5, 1, i + 1, 3);
        end
        push("rearm_init4", STATE_INIT, 0, 2, 5, 0, 3, 2);
        push("rearm_armed4", STATE_ARMED, 0, 2, 5, 0, 3, 2);
        push("rearm_stopped", STATE_STOPPED, 1, 2, 5, 0, 3, 2);
        push("rearm_probe", STATE_STOPPED, 1, 2, 5, 0, 3, DC);
`else
        push("multi_init", STATE_INIT, 0, DC, DC, 0, 0, DC);
        push("multi_armed", STATE_ARMED, 0, DC, DC, 0, 0, 2);
        push("multi_trig", STATE_TRIGGERED, 3, 2, DC, 0, 1, 3);
        push("multi_readout", STATE_READOUT, 5, 2, 5, 1, 1, 3);
        push("multi_stopped", STATE_STOPPED, 5, 2, 5, 0, 1, 2);
        push("multi_probe", STATE_STOPPED, 5, 2, 5, 0, 1, DC);
`endif
        INST_START = 1'b1;
        tick(1);
        INST_START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(2);
            TRIGGER = 1'b1;
            tick(3);
            TRIGGER = 1'b0;
            tick(4);
            READOUT_DONE = 1'b1;
            tick(1);
            READOUT_DONE = 1'b0;
        end
        tick(3);
        INST_STOP = 1'b1;
        tick(1);
        INST_STOP = 1'b0;
        tick(2);
        probe();
        tick(4);

        chk("end", "pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
